// File: rtl/banked_mem_top.sv
// -----------------------------------------------------------------------------
// banked_mem_top
//
// Dual-port (a/b) word memory split into NUM_BANKS single-write banks. Ports
// are granted in the same cycle when they hit different banks. Same-bank
// collisions are settled by a 1-bit round-robin priority register. Reads
// return through a fixed READ_LATENCY-deep pipeline that never stalls.
//
// Optional feature macro: MEM_PARITY_EN
//   defined   : one even-parity bit per byte is stored with each word and
//               checked on every read; err_inj_i corrupts byte-0 parity on
//               granted writes.
//   undefined : no parity storage, P_err_o is always 0, err_inj_i is unused.
//
// Ports (P = a, b)
//   clk_i, rst_i    clock, synchronous active-high reset
//   P_req_i         request
//   P_gnt_o         request accepted this cycle (combinational)
//   P_we_i          1 = write, 0 = read
//   P_be_i          byte enables for writes
//   P_addr_i        word address, bank = low log2(NUM_BANKS) bits
//   P_wdata_i       write data
//   P_rdata_o       read data, held while P_rvalid_o is low
//   P_rvalid_o      read data valid, READ_LATENCY cycles after the grant
//   P_err_o         parity error, qualified by P_rvalid_o
//   err_inj_i       parity error injection for granted writes
// -----------------------------------------------------------------------------
module banked_mem_top #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 12,
   parameter int NUM_BANKS    = 2,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,

   input  logic                    a_req_i,
   output logic                    a_gnt_o,
   input  logic                    a_we_i,
   input  logic [DATA_WIDTH/8-1:0] a_be_i,
   input  logic [ADDR_WIDTH-1:0]   a_addr_i,
   input  logic [DATA_WIDTH-1:0]   a_wdata_i,
   output logic [DATA_WIDTH-1:0]   a_rdata_o,
   output logic                    a_rvalid_o,
   output logic                    a_err_o,

   input  logic                    b_req_i,
   output logic                    b_gnt_o,
   input  logic                    b_we_i,
   input  logic [DATA_WIDTH/8-1:0] b_be_i,
   input  logic [ADDR_WIDTH-1:0]   b_addr_i,
   input  logic [DATA_WIDTH-1:0]   b_wdata_i,
   output logic [DATA_WIDTH-1:0]   b_rdata_o,
   output logic                    b_rvalid_o,
   output logic                    b_err_o,

   input  logic                    err_inj_i
);

   localparam int NBYTES     = DATA_WIDTH / 8;
   localparam int BANK_BITS  = $clog2(NUM_BANKS);
   localparam int SEL_W      = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int IDX_W      = ADDR_WIDTH - BANK_BITS;
   localparam int BANK_DEPTH = 1 << IDX_W;

   // ---------------------------------------------------------------------------
   // Address split
   // ---------------------------------------------------------------------------
   logic [SEL_W-1:0] a_bank, b_bank;
   logic [IDX_W-1:0] a_idx, b_idx;

   if (NUM_BANKS > 1) begin : g_multi_bank
      assign a_bank = a_addr_i[SEL_W-1:0];
      assign b_bank = b_addr_i[SEL_W-1:0];
   end else begin : g_single_bank
      assign a_bank = '0;
      assign b_bank = '0;
   end

   assign a_idx = a_addr_i[ADDR_WIDTH-1:BANK_BITS];
   assign b_idx = b_addr_i[ADDR_WIDTH-1:BANK_BITS];

   // ---------------------------------------------------------------------------
   // Arbitration
   // prio_q = 0: a wins a same-bank collision, 1: b wins. It flips after every
   // collision, so neither port can lose two collisions in a row.
   // ---------------------------------------------------------------------------
   logic same_bank, conflict;
   logic prio_q, prio_d;

   assign same_bank = (a_bank == b_bank);
   assign conflict  = ~rst_i & a_req_i & b_req_i & same_bank;

   assign a_gnt_o = ~rst_i & a_req_i & (~conflict | ~prio_q);
   assign b_gnt_o = ~rst_i & b_req_i & (~conflict |  prio_q);
   assign prio_d  = conflict ? ~prio_q : prio_q;

   // ---------------------------------------------------------------------------
   // Banks
   // At most one port writes a given bank per cycle because a collision grants
   // only one side. The read index is steered to whichever port holds a grant
   // on this bank, falling back to b when a does not.
   // ---------------------------------------------------------------------------
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;
`ifdef MEM_PARITY_EN
   logic [NUM_BANKS-1:0][NBYTES-1:0]     bank_rpar;
`endif

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem_q [BANK_DEPTH];
      logic                  wr_a, wr_b, wr_en;
      logic [IDX_W-1:0]      wr_idx, rd_idx;
      logic [NBYTES-1:0]     wr_be;
      logic [DATA_WIDTH-1:0] wr_data;

      assign wr_a    = a_gnt_o & a_we_i & (a_bank == SEL_W'(g));
      assign wr_b    = b_gnt_o & b_we_i & (b_bank == SEL_W'(g));
      assign wr_en   = wr_a | wr_b;
      assign wr_idx  = wr_a ? a_idx     : b_idx;
      assign wr_be   = wr_a ? a_be_i    : b_be_i;
      assign wr_data = wr_a ? a_wdata_i : b_wdata_i;
      assign rd_idx  = (a_gnt_o & (a_bank == SEL_W'(g))) ? a_idx : b_idx;

      always_ff @(posedge clk_i) begin
         if (wr_en) begin
            for (int j = 0; j < NBYTES; j++) begin
               if (wr_be[j]) begin
                  mem_q[wr_idx][j*8 +: 8] <= wr_data[j*8 +: 8];
               end
            end
         end
      end

      assign bank_rdata[g] = mem_q[rd_idx];

`ifdef MEM_PARITY_EN
      logic [NBYTES-1:0] par_q [BANK_DEPTH];
      logic [NBYTES-1:0] par_wr;

      // Unwritten bytes keep their stored parity; injection flips byte 0
      // regardless of whether byte 0 is enabled.
      always_comb begin
         par_wr = par_q[wr_idx];
         for (int j = 0; j < NBYTES; j++) begin
            if (wr_be[j]) begin
               par_wr[j] = ^wr_data[j*8 +: 8];
            end
         end
         par_wr[0] = par_wr[0] ^ err_inj_i;
      end

      always_ff @(posedge clk_i) begin
         if (wr_en) begin
            par_q[wr_idx] <= par_wr;
         end
      end

      assign bank_rpar[g] = par_q[rd_idx];
`endif
   end

   // ---------------------------------------------------------------------------
   // Read launch
   // ---------------------------------------------------------------------------
   logic [1:0]            rd_fire;
   logic [1:0]            rd_err;
   logic [DATA_WIDTH-1:0] rd_word [2];

   assign rd_fire[0] = a_gnt_o & ~a_we_i;
   assign rd_fire[1] = b_gnt_o & ~b_we_i;
   assign rd_word[0] = bank_rdata[a_bank];
   assign rd_word[1] = bank_rdata[b_bank];

`ifdef MEM_PARITY_EN
   function automatic logic [NBYTES-1:0] byte_par(input logic [DATA_WIDTH-1:0] w);
      logic [NBYTES-1:0] p;
      for (int j = 0; j < NBYTES; j++) begin
         p[j] = ^w[j*8 +: 8];
      end
      return p;
   endfunction

   assign rd_err[0] = |(byte_par(rd_word[0]) ^ bank_rpar[a_bank]);
   assign rd_err[1] = |(byte_par(rd_word[1]) ^ bank_rpar[b_bank]);
`else
   logic unused_err_inj;

   assign unused_err_inj = err_inj_i;
   assign rd_err         = 2'b00;
`endif

   // ---------------------------------------------------------------------------
   // Read return pipeline, one per port
   // Stage data only advances behind a valid, so the last stage naturally holds
   // the most recent returned word while rvalid is low.
   // ---------------------------------------------------------------------------
   logic [READ_LATENCY-1:0] pvld_q  [2];
   logic [READ_LATENCY-1:0] perr_q  [2];
   logic [DATA_WIDTH-1:0]   pdata_q [2][READ_LATENCY];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= 1'b0;
         for (int p = 0; p < 2; p++) begin
            pvld_q[p] <= '0;
            perr_q[p] <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
               pdata_q[p][s] <= '0;
            end
         end
      end else begin
         prio_q <= prio_d;
         for (int p = 0; p < 2; p++) begin
            pvld_q[p][0] <= rd_fire[p];
            perr_q[p][0] <= rd_fire[p] & rd_err[p];
            if (rd_fire[p]) begin
               pdata_q[p][0] <= rd_word[p];
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
               pvld_q[p][s] <= pvld_q[p][s-1];
               perr_q[p][s] <= perr_q[p][s-1];
               if (pvld_q[p][s-1]) begin
                  pdata_q[p][s] <= pdata_q[p][s-1];
               end
            end
         end
      end
   end

   assign a_rvalid_o = pvld_q[0][READ_LATENCY-1];
   assign a_rdata_o  = pdata_q[0][READ_LATENCY-1];
   assign a_err_o    = pvld_q[0][READ_LATENCY-1] & perr_q[0][READ_LATENCY-1];

   assign b_rvalid_o = pvld_q[1][READ_LATENCY-1];
   assign b_rdata_o  = pdata_q[1][READ_LATENCY-1];
   assign b_err_o    = pvld_q[1][READ_LATENCY-1] & perr_q[1][READ_LATENCY-1];

endmodule

// File: tb/tb_banked_mem_top.sv
`timescale 1ns/1ps
module tb_banked_mem_top;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int NB = 2;
   localparam int RL = 2;
`ifdef MEM_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, err_inj;
   logic          a_req, a_gnt, a_we, a_rvalid, a_err;
   logic [3:0]    a_be;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata, a_rdata;
   logic          b_req, b_gnt, b_we, b_rvalid, b_err;
   logic [3:0]    b_be;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata, b_rdata;

   banked_mem_top #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .NUM_BANKS    (NB),
      .READ_LATENCY (RL)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .a_req_i    (a_req),
      .a_gnt_o    (a_gnt),
      .a_we_i     (a_we),
      .a_be_i     (a_be),
      .a_addr_i   (a_addr),
      .a_wdata_i  (a_wdata),
      .a_rdata_o  (a_rdata),
      .a_rvalid_o (a_rvalid),
      .a_err_o    (a_err),
      .b_req_i    (b_req),
      .b_gnt_o    (b_gnt),
      .b_we_i     (b_we),
      .b_be_i     (b_be),
      .b_addr_i   (b_addr),
      .b_wdata_i  (b_wdata),
      .b_rdata_o  (b_rdata),
      .b_rvalid_o (b_rvalid),
      .b_err_o    (b_err),
      .err_inj_i  (err_inj)
   );

   typedef struct {
      logic          req;
      logic          we;
      logic [3:0]    be;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
   } port_t;

   typedef struct {
      logic  rst;
      logic  inj;
      port_t a;
      port_t b;
      logic  ga;
      logic  gb;
   } vec_t;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   vec_t          vecs[$];
   exp_t          sb [2][$];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic          ref_bad [logic [AW-1:0]];
   logic [DW-1:0] last_rd [2];
   int            cyc   = 0;
   int            n_vec = 0;
   int            n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic port_t nop();
      port_t p;
      p = '{1'b0, 1'b0, 4'h0, 12'h000, 32'h0};
      return p;
   endfunction

   function automatic port_t rd(input logic [AW-1:0] ad);
      port_t p;
      p = '{1'b1, 1'b0, 4'h0, ad, 32'h0};
      return p;
   endfunction

   function automatic port_t wr(input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic [3:0] be);
      port_t p;
      p = '{1'b1, 1'b1, be, ad, wd};
      return p;
   endfunction

   function automatic vec_t v(input logic r, input logic inj, input port_t pa, input port_t pb,
                              input logic ga, input logic gb);
      vec_t x;
      x = '{r, inj, pa, pb, ga, gb};
      return x;
   endfunction

   // Output monitor: one rvalid/rdata/err check per port per clock.
   always @(posedge clk) begin
      logic          rs, ev, rv, erv;
      logic [DW-1:0] rdv;
      exp_t          e;
      rs = rst;
      cyc++;
      #1;
      if (rs) begin
         sb[0].delete();
         sb[1].delete();
         last_rd[0] = '0;
         last_rd[1] = '0;
      end
      for (int p = 0; p < 2; p++) begin
         rv  = (p == 0) ? a_rvalid : b_rvalid;
         rdv = (p == 0) ? a_rdata  : b_rdata;
         erv = (p == 0) ? a_err    : b_err;
         ev  = (sb[p].size() > 0) && (sb[p][0].due == cyc);
         e   = '{0, '0, 1'b0};
         if (ev) begin
            e          = sb[p].pop_front();
            last_rd[p] = e.data;
         end
         check($sformatf("rvalid port%0d", p), 32'(rv), 32'(ev));
         check($sformatf("rdata port%0d", p), rdv, last_rd[p]);
         check($sformatf("err port%0d", p), 32'(erv), 32'(e.err));
      end
   end

   task automatic model_port(input port_t pp, input logic g, input logic inj, input int p);
      exp_t          e;
      logic [DW-1:0] w;
      if (g && !pp.we) begin
         e.due  = cyc + RL;
         e.data = ref_mem[pp.addr];
         e.err  = PAR & ref_bad[pp.addr];
         sb[p].push_back(e);
      end
   endtask

   task automatic model_write(input port_t pp, input logic g, input logic inj);
      logic [DW-1:0] w;
      logic          bad;
      if (g && pp.we) begin
         w   = ref_mem.exists(pp.addr) ? ref_mem[pp.addr] : '0;
         bad = ref_bad.exists(pp.addr) ? ref_bad[pp.addr] : 1'b0;
         for (int j = 0; j < 4; j++) begin
            if (pp.be[j]) w[j*8 +: 8] = pp.wd[j*8 +: 8];
         end
         if (pp.be[0]) bad = 1'b0;
         ref_mem[pp.addr] = w;
         ref_bad[pp.addr] = bad ^ inj;
      end
   endtask

   initial begin
      rst = 1'b1; err_inj = 1'b0;
      a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;

      vecs.push_back(v(1, 0, nop(), nop(), 0, 0));
      vecs.push_back(v(1, 0, rd(12'h000), rd(12'h002), 0, 0));
      vecs.push_back(v(0, 0, wr(12'h004, 32'hDEADBEEF, 4'hF), nop(), 1, 0));
      vecs.push_back(v(0, 0, rd(12'h004), nop(), 1, 0));
      vecs.push_back(v(0, 0, wr(12'h008, 32'h11223344, 4'hF), nop(), 1, 0));
      vecs.push_back(v(0, 0, nop(), wr(12'h008, 32'hAABBCCDD, 4'h5), 0, 1));
      vecs.push_back(v(0, 0, rd(12'h008), nop(), 1, 0));
      vecs.push_back(v(0, 0, wr(12'h008, 32'hFFFFFFFF, 4'h0), nop(), 1, 0));
      vecs.push_back(v(0, 0, rd(12'h008), nop(), 1, 0));
      vecs.push_back(v(0, 0, wr(12'h010, 32'hCAFE0010, 4'hF), wr(12'h011, 32'hCAFE0011, 4'hF), 1, 1));
      vecs.push_back(v(0, 0, rd(12'h010), rd(12'h011), 1, 1));
      vecs.push_back(v(0, 0, wr(12'h000, 32'hA0A0A0A0, 4'hF), wr(12'h003, 32'hB3B3B3B3, 4'hF), 1, 1));
      vecs.push_back(v(0, 0, nop(), wr(12'h002, 32'hC2C2C2C2, 4'hF), 0, 1));
      vecs.push_back(v(0, 0, rd(12'h000), rd(12'h002), 1, 0));
      vecs.push_back(v(0, 0, rd(12'h000), rd(12'h002), 0, 1));
      vecs.push_back(v(0, 0, rd(12'h000), rd(12'h002), 1, 0));
      vecs.push_back(v(0, 0, wr(12'h006, 32'h66666666, 4'hF), wr(12'h00A, 32'hAAAA000A, 4'hF), 0, 1));
      vecs.push_back(v(0, 0, rd(12'h00A), nop(), 1, 0));
      vecs.push_back(v(0, 0, nop(), rd(12'h003), 0, 1));
      vecs.push_back(v(0, 0, nop(), rd(12'h011), 0, 1));
      vecs.push_back(v(0, 0, nop(), rd(12'h002), 0, 1));
      vecs.push_back(v(0, 1, wr(12'h020, 32'h000000FF, 4'hF), nop(), 1, 0));
      vecs.push_back(v(0, 0, rd(12'h020), nop(), 1, 0));
      vecs.push_back(v(0, 0, rd(12'h000), rd(12'h002), 1, 0));
      vecs.push_back(v(0, 0, rd(12'h004), nop(), 1, 0));
      vecs.push_back(v(1, 0, wr(12'h004, 32'h12345678, 4'hF), nop(), 0, 0));
      vecs.push_back(v(0, 0, rd(12'h000), rd(12'h002), 1, 0));
      vecs.push_back(v(0, 0, rd(12'h004), nop(), 1, 0));
      vecs.push_back(v(0, 0, rd(12'h011), rd(12'h010), 1, 1));

      foreach (vecs[i]) begin
         @(negedge clk);
         rst     = vecs[i].rst;
         err_inj = vecs[i].inj;
         a_req = vecs[i].a.req; a_we = vecs[i].a.we; a_be = vecs[i].a.be;
         a_addr = vecs[i].a.addr; a_wdata = vecs[i].a.wd;
         b_req = vecs[i].b.req; b_we = vecs[i].b.we; b_be = vecs[i].b.be;
         b_addr = vecs[i].b.addr; b_wdata = vecs[i].b.wd;
         #1;
         check($sformatf("a_gnt vec%0d", i), 32'(a_gnt), 32'(vecs[i].ga));
         check($sformatf("b_gnt vec%0d", i), 32'(b_gnt), 32'(vecs[i].gb));
         // Reads see memory as of the grant edge, so model them before writes.
         model_port(vecs[i].a, vecs[i].ga, vecs[i].inj, 0);
         model_port(vecs[i].b, vecs[i].gb, vecs[i].inj, 1);
         model_write(vecs[i].a, vecs[i].ga, vecs[i].inj);
         model_write(vecs[i].b, vecs[i].gb, vecs[i].inj);
      end

      @(negedge clk);
      rst = 1'b0; err_inj = 1'b0; a_req = 1'b0; b_req = 1'b0;
      repeat (RL + 3) @(negedge clk);
      check("drain port0", 32'(sb[0].size()), 32'd0);
      check("drain port1", 32'(sb[1].size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/banked_mem_top.md
BANKED_MEM_TOP -- requirements
Module: banked_mem_top

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, word address width.
REQ-003 SHALL have parameter NUM_BANKS, default 2, power of two, 1..8; bank = addr[log2(NUM_BANKS)-1:0].
REQ-004 SHALL have parameter READ_LATENCY, default 1, range 1..4, cycles from grant to rvalid.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have, for each port P in {a, b}, the following signals:
- P_req_i, input, 1, request.
- P_gnt_o, output, 1, request accepted this cycle.
- P_we_i, input, 1, write.
- P_be_i, input, DATA_WIDTH/8, byte enables.
- P_addr_i, input, ADDR_WIDTH, word address.
- P_wdata_i, input, DATA_WIDTH, write data.
- P_rdata_o, output, DATA_WIDTH, read data.
- P_rvalid_o, output, 1, read data valid.
- P_err_o, output, 1, parity error, qualified by P_rvalid_o.
REQ-008 SHALL have port err_inj_i, input, 1; when high, flips the stored parity of byte 0 on any write granted that cycle.

Function
REQ-009 SHALL hold 2^ADDR_WIDTH words split across NUM_BANKS banks; each bank holds 2^ADDR_WIDTH/NUM_BANKS words; bank-local index = addr >> log2(NUM_BANKS).
REQ-010 SHALL make P_gnt_o combinational from the request inputs and the priority state; it is asserted only when P_req_i is high.
REQ-011 SHALL grant both ports in the same cycle when they target different banks.
REQ-012 SHALL resolve same-bank conflicts with a 1-bit round-robin priority register (reset value: a has priority).
- Only the priority port is granted.
- The register toggles after each conflict.
- No port loses more than one consecutive conflict.
REQ-013 SHALL, on a granted write, update only the bytes whose P_be_i bit is 1, at the granting clock edge.
- Granted writes SHALL NOT produce P_rvalid_o.
- A write with P_be_i = 0 is a granted no-op.
REQ-014 SHALL, on a granted read, assert P_rvalid_o exactly READ_LATENCY cycles after the grant cycle, for one cycle, with P_rdata_o holding the word as of the grant edge.
REQ-015 SHALL accept back-to-back reads on one port every cycle; the rvalid and rdata pipeline is READ_LATENCY stages deep and never stalls.
REQ-016 SHALL hold P_rdata_o at its last valid value while P_rvalid_o is low.
REQ-017 SHALL return newly written data for a read granted at least one cycle after the write to the same address, from either port.
REQ-018 SHALL ignore address bits only through the bank mapping; there is no out-of-range case, because depth is exactly 2^ADDR_WIDTH.

Reset
REQ-019 SHALL, while rst_i is high at a clock edge:
- clear all P_rvalid_o and P_err_o;
- clear all pipeline valid stages;
- set P_rdata_o to 0;
- reset the priority register to port a.
REQ-020 SHALL drop any read in flight when reset is asserted; no rvalid is produced for it after reset.
REQ-021 SHALL suppress grants while rst_i is high: P_gnt_o = 0 and no memory writes occur.
REQ-022 SHALL NOT clear memory contents on reset.

Configuration
REQ-023 SHALL implement macro MEM_PARITY_EN as follows.
- When defined: store one even-parity bit per byte; recompute parity on every read. Assert P_err_o with P_rvalid_o if any byte of the returned word mismatches its stored parity. err_inj_i is honoured.
- When not defined: no parity storage; P_err_o tied to 0; err_inj_i ignored.

Verification
REQ-024 SHALL cover the following directed scenarios:
- a writes 0xDEADBEEF to addr 0x004 with be=0xF; then a reads 0x004 with READ_LATENCY=2 -> a_rvalid_o high exactly 2 cycles after the read grant, a_rdata_o=0xDEADBEEF.
- Addr 0x008 holds 0x11223344; b writes 0xAABBCCDD with be=0x5 -> subsequent read returns 0x11BB33DD.
- a reads 0x010 and b reads 0x011 in the same cycle (NUM_BANKS=2) -> both granted; both rvalid in the same later cycle.
- a and b request bank 0 (0x000, 0x002) for 3 consecutive cycles -> grants a, b, a.
- Read granted, then rst_i pulsed the next cycle -> no rvalid afterwards; memory word unchanged on a later read.
- With MEM_PARITY_EN defined: write 0x000000FF with err_inj_i=1, then read -> rvalid with P_err_o=1. Without the macro, the same stimulus gives P_err_o=0 and rdata=0x000000FF.
